// File: rtl/modn_updown_prog_if.sv
// Control/status bundle of the programmable mod-N up/down counter.
// The master side drives the controls and observes count/tc/wrap;
// the slave side is the counter itself.
interface modn_updown_prog_if #(
  parameter int N_MAX = 10,
  parameter int W     = (N_MAX < 2) ? 1 : $clog2(N_MAX)
);
  logic         en;
  logic         up;
  logic         sat;
  logic [W-1:0] limit;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] count;
  logic         tc;
  logic         wrap;

  modport master (
    output en, up, sat, limit, load, load_val,
    input  count, tc, wrap
  );

  modport slave (
    input  en, up, sat, limit, load, load_val,
    output count, tc, wrap
  );
endinterface

// File: rtl/modn_updown_prog.sv
// Programmable mod-N up/down counter with runtime terminal value,
// parallel load, wrap/saturate mode, combinational terminal count for
// cascading and a registered wrap-event pulse.
module modn_updown_prog #(
  parameter int N_MAX = 10
) (
  input logic              clk,
  input logic              rst,
  modn_updown_prog_if.slave bus
);
  localparam int           W    = (N_MAX < 2) ? 1 : $clog2(N_MAX);
  localparam logic [W-1:0] ZERO = {W{1'b0}};
  localparam logic [W-1:0] ONE  = W'(1'b1);

  logic [W-1:0] count_r;
  logic         wrap_r;
  logic [W-1:0] count_nxt_s;
  logic         wrap_nxt_s;
  logic [W-1:0] load_clamp_s;
  logic         at_top_s;
  logic         at_bot_s;
  logic         over_s;

  assign at_top_s     = (count_r == bus.limit);
  assign at_bot_s     = (count_r == ZERO);
  // A lowered limit can leave the count above the terminal value.
  assign over_s       = (count_r > bus.limit);
  assign load_clamp_s = (bus.load_val > bus.limit) ? bus.limit : bus.load_val;

  // Next count and wrap event: load beats enable; reset is applied in the register.
  always_comb begin
    count_nxt_s = count_r;
    wrap_nxt_s  = 1'b0;
    if (bus.load) begin
      count_nxt_s = load_clamp_s;
    end else if (bus.en) begin
      if (over_s) begin
        // Out-of-range recovery never reports a wrap.
        count_nxt_s = (bus.up && !bus.sat) ? ZERO : bus.limit;
      end else if (bus.up) begin
        if (!at_top_s) begin
          count_nxt_s = count_r + ONE;
        end else if (!bus.sat) begin
          count_nxt_s = ZERO;
          wrap_nxt_s  = 1'b1;
        end else begin
          count_nxt_s = count_r;
        end
      end else begin
        if (!at_bot_s) begin
          count_nxt_s = count_r - ONE;
        end else if (!bus.sat) begin
          count_nxt_s = bus.limit;
          wrap_nxt_s  = 1'b1;
        end else begin
          count_nxt_s = count_r;
        end
      end
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Count and wrap registers; reset start point depends on direction.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= bus.up ? ZERO : bus.limit;
      wrap_r  <= 1'b0;
    end else begin
      count_r <= count_nxt_s;
      wrap_r  <= wrap_nxt_s;
    end
  end

  assign bus.count = count_r;
  assign bus.wrap  = wrap_r;
  // Terminal count is combinational so a following stage steps on the same edge.
  assign bus.tc    = bus.en & ~rst & ((bus.up & at_top_s) | (~bus.up & at_bot_s));

  modn_updown_prog_chk #(.N_MAX(N_MAX), .W(W)) u_chk (
    .clk   (clk),
    .rst   (rst),
    .limit (bus.limit)
  );
endmodule

// Flags a terminal value beyond the supported modulus.
module modn_updown_prog_chk #(
  parameter int N_MAX = 10,
  parameter int W     = 4
) (
  input logic         clk,
  input logic         rst,
  input logic [W-1:0] limit
);
  localparam logic [W-1:0] LIM_MAX = W'(N_MAX - 1);

  limit_legal_a : assert property (@(posedge clk) disable iff (rst) (limit <= LIM_MAX));
endmodule

// File: tb/tb_modn_updown_prog.sv
// Scoreboard bench for modn_updown_prog: stimulus pushes the values the
// counters must show in each cycle, a monitor pops and compares them.
module tb_modn_updown_prog;
  logic clk = 1'b0;
  logic rst;
  logic cas_rst;

  always #5 clk = ~clk;

  modn_updown_prog_if #(.N_MAX(10)) m_if ();
  modn_updown_prog_if #(.N_MAX(10)) u_if ();
  modn_updown_prog_if #(.N_MAX(10)) t_if ();

  modn_updown_prog #(.N_MAX(10)) dut   (.clk(clk), .rst(rst),     .bus(m_if));
  modn_updown_prog #(.N_MAX(10)) units (.clk(clk), .rst(cas_rst), .bus(u_if));
  modn_updown_prog #(.N_MAX(10)) tens  (.clk(clk), .rst(cas_rst), .bus(t_if));

  assign t_if.en = u_if.tc;

  typedef struct {
    int         sel;
    logic [3:0] c0;
    logic [3:0] c1;
    logic       t;
    logic       w0;
    logic       w1;
    string      nm;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  logic cas_on = 1'b0;
  int uw_cnt = 0;
  int tw_cnt = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compare every pending expectation once the cycle has settled.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.sel == 0) begin
          chk({e.nm, ".count"}, int'(m_if.count), int'(e.c0));
          chk({e.nm, ".tc"},    int'(m_if.tc),    int'(e.t));
          chk({e.nm, ".wrap"},  int'(m_if.wrap),  int'(e.w0));
        end else begin
          chk({e.nm, ".units"},  int'(u_if.count), int'(e.c0));
          chk({e.nm, ".tens"},   int'(t_if.count), int'(e.c1));
          chk({e.nm, ".u_tc"},   int'(u_if.tc),    int'(e.t));
          chk({e.nm, ".u_wrap"}, int'(u_if.wrap),  int'(e.w0));
          chk({e.nm, ".t_wrap"}, int'(t_if.wrap),  int'(e.w1));
        end
      end
    end
  end

  // Wrap pulse counters for the cascade pair.
  always @(negedge clk) begin
    #1;
    if (!cas_on) begin
      uw_cnt = 0;
      tw_cnt = 0;
    end else begin
      if (u_if.wrap) uw_cnt++;
      if (t_if.wrap) tw_cnt++;
    end
  end

  // One cycle on the single counter: apply inputs, queue what this cycle must show.
  task automatic cyc(input logic r, input logic ld, input logic e, input logic u,
                     input logic s, input logic [3:0] lim, input logic [3:0] lv,
                     input logic [3:0] ec, input logic et, input logic ew,
                     input string nm);
    exp_t x;
    @(negedge clk);
    rst = r; m_if.load = ld; m_if.en = e; m_if.up = u; m_if.sat = s;
    m_if.limit = lim; m_if.load_val = lv;
    x.sel = 0; x.c0 = ec; x.c1 = 4'd0; x.t = et; x.w0 = ew; x.w1 = 1'b0; x.nm = nm;
    sb.push_back(x);
  endtask

  initial begin
    exp_t x;
    rst = 1'b1; m_if.en = 1'b0; m_if.up = 1'b1; m_if.sat = 1'b0;
    m_if.limit = 4'd9; m_if.load = 1'b0; m_if.load_val = 4'd0;
    cas_rst = 1'b1;
    u_if.en = 1'b0; u_if.up = 1'b1; u_if.sat = 1'b0; u_if.limit = 4'd9;
    u_if.load = 1'b0; u_if.load_val = 4'd0;
    t_if.up = 1'b1; t_if.sat = 1'b0; t_if.limit = 4'd9;
    t_if.load = 1'b0; t_if.load_val = 4'd0;
    @(negedge clk);

    // wrap-mode count up through 9 -> 0
    for (int k = 0; k < 12; k++)
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd9, 4'd0, 4'(k % 10), k == 9, k == 10, "t1");
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd9, 4'd0, 4'd2, 1'b0, 1'b0, "t1_hold");

    // reset with up=0 starts at limit, count down through 0 -> 9
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd9, 4'd0, 4'd2, 1'b0, 1'b0, "t2_rst");
    for (int k = 0; k < 11; k++)
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd9, 4'd0, (k <= 9) ? 4'(9 - k) : 4'd9,
          k == 9, k == 10, "t2");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd9, 4'd0, 4'd8, 1'b0, 1'b0, "t2_hold");

    // saturate mode, limit 5, load 3
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd5, 4'd3, 4'd8, 1'b0, 1'b0, "t3_load");
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd5, 4'd0, 4'd3, 1'b0, 1'b0, "t3_up0");
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd5, 4'd0, 4'd4, 1'b0, 1'b0, "t3_up1");
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd5, 4'd0, 4'd5, 1'b1, 1'b0, "t3_up2");
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd5, 4'd0, 4'd5, 1'b1, 1'b0, "t3_up3");
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd5, 4'd0, 4'd5, 1'b0, 1'b0, "t3_dn0");
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd5, 4'd0, 4'd4, 1'b0, 1'b0, "t3_dn1");
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd5, 4'd0, 4'd3, 1'b0, 1'b0, "t3_dn2");
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd5, 4'd0, 4'd2, 1'b0, 1'b0, "t3_dn3");
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd5, 4'd0, 4'd1, 1'b0, 1'b0, "t3_dn4");
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd5, 4'd0, 4'd0, 1'b1, 1'b0, "t3_dn5");
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd5, 4'd0, 4'd0, 1'b1, 1'b0, "t3_dn6");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 4'd0, 4'd0, 1'b0, 1'b0, "t3_hold");

    // load clamp beats enable; reset beats load
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd7, 4'd12, 4'd0, 1'b0, 1'b0, "t4_load_en");
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd7, 4'd12, 4'd7, 1'b0, 1'b0, "t4_rst_load");
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd7, 4'd0, 4'd0, 1'b0, 1'b0, "t4_after_rst");

    // runtime limit lowered below the count
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd9, 4'd8, 4'd0, 1'b0, 1'b0, "t5_load8");
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd4, 4'd0, 4'd8, 1'b0, 1'b0, "t5_hold_oor");
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd4, 4'd0, 4'd8, 1'b0, 1'b0, "t5_up_oor");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd9, 4'd8, 4'd0, 1'b0, 1'b0, "t5_up_res");
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd4, 4'd0, 4'd8, 1'b0, 1'b0, "t5_dn_oor");
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd9, 4'd8, 4'd4, 1'b0, 1'b0, "t5_dn_res");
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd4, 4'd0, 4'd8, 1'b0, 1'b0, "t5_sat_oor");
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd4, 1'b0, 1'b0, "t5_sat_res");

    // limit 0: every enabled wrap-mode step is a wrap
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 4'd4, 1'b0, 1'b0, "l0_fix");
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, "l0_up");
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b1, "l0_dn");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, "l0_idle");
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd9, 4'd0, 4'd0, 1'b0, 1'b0, "l0_end");

    // two-digit cascade: units tc drives tens en
    @(negedge clk);
    cas_rst = 1'b1;
    u_if.en = 1'b0;
    for (int k = 0; k <= 100; k++) begin
      @(negedge clk);
      cas_rst = 1'b0;
      cas_on  = 1'b1;
      u_if.en = (k < 100);
      x.sel = 1;
      x.c0  = 4'(k % 10);
      x.c1  = 4'((k / 10) % 10);
      x.t   = (k % 10 == 9) && (k < 100);
      x.w0  = (k > 0) && (k % 10 == 0);
      x.w1  = (k == 100);
      x.nm  = $sformatf("cas%0d", k);
      sb.push_back(x);
    end
    @(negedge clk);
    #3;
    cas_on = 1'b0;
    chk("cas_units_wraps", uw_cnt, 10);
    chk("cas_tens_wraps", tw_cnt, 1);
    chk("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
